// File: rtl/decode_imm_pkg.sv
// Shared opcode constants, FSM state encoding and the buffered entry layout
// for the decode-stage immediate sequencer.
package decode_imm_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FMA_LO = 7'b1000011;
  localparam logic [6:0] OP_FMA_HI = 7'b1001111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // fmt is {j_type, b_type, s_type, lui, auipc}
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  fmt;
    logic        illegal;
  } id_entry_t;

  // FMADD/FMSUB/FNMSUB/FNMADD: the four opcodes 10000_11 .. 10011_11
  function automatic logic is_fma(input logic [6:0] op);
    return (op[1:0] == 2'b11) && (op >= OP_FMA_LO) && (op <= OP_FMA_HI);
  endfunction

endpackage

// File: rtl/decode_imm_ctrl_imm_gen.sv
// Immediate generator: builds the sign-extended immediate from the format
// selects; with no select asserted it produces the I-format immediate.
module imm_gen (
  input  logic [31:0] i_inst,
  input  logic        i_j,
  input  logic        i_b,
  input  logic        i_s,
  input  logic        i_lui,
  input  logic        i_auipc,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = {{21{i_inst[31]}}, i_inst[30:20]};
    if (i_j) begin
      o_imm = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    end else if (i_b) begin
      o_imm = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    end else if (i_s) begin
      o_imm = {{21{i_inst[31]}}, i_inst[30:25], i_inst[11:7]};
    end else if (i_lui || i_auipc) begin
      o_imm = {i_inst[31:12], 12'b0};
    end
  end

endmodule

// File: rtl/decode_imm_ctrl.sv
// Decode-stage sequencer: classifies the fetched opcode, captures the
// immediate at accept time and holds up to two entries for execute.
module decode_imm_ctrl
  import decode_imm_pkg::*;
#(
  parameter bit EN_FP_STORE    = 1'b1,
  parameter bit ILLEGAL_DETECT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_fmt,
  output logic        ex_illegal,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid holds its payload until taken, ready never depends
  // combinationally on the opposite side's valid/ready.

  state_t      r_state;
  logic        r_id_ready;
  logic        r_ex_valid;
  id_entry_t   r_main;
  id_entry_t   r_skid;

  logic [6:0]  w_op;
  logic [4:0]  w_fmt;
  logic        w_legal_ir;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic        w_in_xfer;
  logic        w_out_xfer;
  id_entry_t   w_new;

  assign w_op = if_inst[6:0];

  always_comb begin
    w_fmt = 5'b00000;
    case (w_op)
      OP_JAL:    w_fmt = 5'b10000;
      OP_BRANCH: w_fmt = 5'b01000;
      OP_STORE:  w_fmt = 5'b00100;
      OP_FSTORE: w_fmt = EN_FP_STORE ? 5'b00100 : 5'b00000;
      OP_LUI:    w_fmt = 5'b00010;
      OP_AUIPC:  w_fmt = 5'b00001;
      default:   w_fmt = 5'b00000;
    endcase
  end

  always_comb begin
    w_legal_ir = 1'b0;
    case (w_op)
      OP_LOAD, OP_FLOAD, OP_OPIMM, OP_OP, OP_JALR,
      OP_SYSTEM, OP_FENCE, OP_FP: w_legal_ir = 1'b1;
      default:                    w_legal_ir = is_fma(w_op);
    endcase
  end

  assign w_illegal = ILLEGAL_DETECT && (w_fmt == 5'b00000) && !w_legal_ir;

  imm_gen u_imm_gen (
    .i_inst  (if_inst),
    .i_j     (w_fmt[4]),
    .i_b     (w_fmt[3]),
    .i_s     (w_fmt[2]),
    .i_lui   (w_fmt[1]),
    .i_auipc (w_fmt[0]),
    .o_imm   (w_imm)
  );

  assign w_new = '{inst: if_inst, pc: if_pc, imm: w_imm, fmt: w_fmt, illegal: w_illegal};

  assign w_in_xfer  = if_valid && r_id_ready;
  assign w_out_xfer = r_ex_valid && ex_ready;

  // Entry payloads only load on accept; validity lives in r_state alone.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state    <= EMPTY;
      r_id_ready <= 1'b1;
      r_ex_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            r_main     <= w_new;
            r_state    <= ONE;
            r_ex_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_new;
          end else if (w_in_xfer) begin
            r_skid     <= w_new;
            r_state    <= TWO;
            r_id_ready <= 1'b0;
          end else if (w_out_xfer) begin
            r_state    <= EMPTY;
            r_ex_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_id_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_id_ready <= 1'b1;
          r_ex_valid <= 1'b0;
        end
      endcase
    end
  end

  assign id_ready   = r_id_ready;
  assign ex_valid   = r_ex_valid;
  assign ex_inst    = r_ex_valid ? r_main.inst    : 32'h0;
  assign ex_pc      = r_ex_valid ? r_main.pc      : 32'h0;
  assign ex_imm     = r_ex_valid ? r_main.imm     : 32'h0;
  assign ex_fmt     = r_ex_valid ? r_main.fmt     : 5'h0;
  assign ex_illegal = r_ex_valid ? r_main.illegal : 1'b0;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Bench for decode_imm_ctrl: directed scenarios plus a random stream checked
// against a two-deep FIFO model and spec-level immediate rules.
module tb_decode_imm_ctrl;
  import decode_imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = 32'h0;
  logic [31:0] if_pc = 32'h0;
  logic        ex_ready = 1'b0;

  logic        id_ready, ex_valid, ex_illegal;
  logic [31:0] ex_inst, ex_pc, ex_imm;
  logic [4:0]  ex_fmt;
  logic [1:0]  dbg_state;

  logic        nf_id_ready, nf_ex_valid, nf_ex_illegal;
  logic [31:0] nf_ex_inst, nf_ex_pc, nf_ex_imm;
  logic [4:0]  nf_ex_fmt;
  logic [1:0]  nf_dbg_state;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pc_q[$];

  always #5 clk = ~clk;

  decode_imm_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_fmt(ex_fmt),
    .ex_illegal(ex_illegal), .dbg_state(dbg_state)
  );

  decode_imm_ctrl #(.EN_FP_STORE(1'b0)) dut_nofp (
    .clk(clk), .reset(reset), .flush(flush), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .id_ready(nf_id_ready),
    .ex_valid(nf_ex_valid), .ex_ready(ex_ready), .ex_inst(nf_ex_inst),
    .ex_pc(nf_ex_pc), .ex_imm(nf_ex_imm), .ex_fmt(nf_ex_fmt),
    .ex_illegal(nf_ex_illegal), .dbg_state(nf_dbg_state)
  );

  function automatic logic [4:0] ref_fmt(input logic [31:0] i, input bit en_fp);
    case (i[6:0])
      7'b1101111: return 5'b10000;
      7'b1100011: return 5'b01000;
      7'b0100011: return 5'b00100;
      7'b0100111: return en_fp ? 5'b00100 : 5'b00000;
      7'b0110111: return 5'b00010;
      7'b0010111: return 5'b00001;
      default:    return 5'b00000;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i, input bit en_fp);
    if (ref_fmt(i, en_fp) != 5'b00000) return 1'b0;
    case (i[6:0])
      7'b0000011, 7'b0000111, 7'b0010011, 7'b0110011, 7'b1100111,
      7'b1110011, 7'b0001111, 7'b1010011,
      7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Immediate value as a signed integer, built from the field positions.
  function automatic logic [31:0] ref_imm(input logic [31:0] i, input bit en_fp);
    logic [4:0] f;
    int v;
    f = ref_fmt(i, en_fp);
    if (f[4]) begin
      v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
      if (i[31]) v = v - (1 << 20);
    end else if (f[3]) begin
      v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048;
      if (i[31]) v = v - 4096;
    end else if (f[2]) begin
      v = int'(i[11:7]) + int'(i[30:25]) * 32;
      if (i[31]) v = v - 2048;
    end else if (f[1] || f[0]) begin
      v = int'(i[31:12]) << 12;
    end else begin
      v = int'(i[30:20]);
      if (i[31]) v = v - 2048;
    end
    return 32'(v);
  endfunction

  // Advances one clock and updates the FIFO model from the inputs seen at the edge.
  task automatic cycle();
    bit in_x, out_x;
    in_x  = if_valid && (exp_q.size() < 2);
    out_x = (exp_q.size() > 0) && ex_ready;
    @(posedge clk);
    if (reset || flush) begin
      exp_q.delete();
      pc_q.delete();
    end else begin
      if (out_x) begin
        void'(exp_q.pop_front());
        void'(pc_q.pop_front());
      end
      if (in_x) begin
        exp_q.push_back(if_inst);
        pc_q.push_back(if_pc);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b exp 1", id_ready); end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
    checks++; if ({ex_inst, ex_pc, ex_imm, ex_fmt, ex_illegal} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h %h %h %b %b exp all 0", ex_inst, ex_pc, ex_imm, ex_fmt, ex_illegal);
    end
    checks++; if (dbg_state !== EMPTY) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, EMPTY); end
  endtask

  task automatic test_formats();
    logic [31:0] vin[5]  = '{32'h0080006F, 32'hFE000EE3, 32'hFE112C23, 32'h123450B7, 32'hFFF00093};
    logic [31:0] vimm[5] = '{32'h00000008, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFFF};
    logic [4:0]  vfmt[5] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00000};
    logic [31:0] pc;
    ex_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc = $urandom() & 32'hFFFF_FFFC;
      if_valid = 1'b1; if_inst = vin[k]; if_pc = pc;
      cycle();
      if_valid = 1'b0;
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_valid got %b exp 1", k, ex_valid); end
      checks++; if (ex_inst !== vin[k] || ex_pc !== pc) begin errors++; $display("FAIL fmt%0d_inst_pc got %h/%h exp %h/%h", k, ex_inst, ex_pc, vin[k], pc); end
      checks++; if (ex_imm !== vimm[k]) begin errors++; $display("FAIL fmt%0d_imm got %h exp %h", k, ex_imm, vimm[k]); end
      checks++; if (ex_fmt !== vfmt[k]) begin errors++; $display("FAIL fmt%0d_fmt got %b exp %b", k, ex_fmt, vfmt[k]); end
      checks++; if (ex_illegal !== 1'b0) begin errors++; $display("FAIL fmt%0d_illegal got %b exp 0", k, ex_illegal); end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] seq[3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    bit c_taken;
    ex_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_valid = 1'b1; if_inst = seq[k]; if_pc = 32'h100 + 32'(4 * k);
      cycle();
    end
    if_inst = seq[2]; if_pc = 32'h108;
    cycle();
    cycle();
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_id_ready got %b exp 0", id_ready); end
    checks++; if (ex_inst !== seq[0]) begin errors++; $display("FAIL bp_head got %h exp %h", ex_inst, seq[0]); end
    checks++; if (dbg_state !== TWO) begin errors++; $display("FAIL bp_state got %0d exp %0d", dbg_state, TWO); end
    ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ex_valid !== 1'b1 || ex_inst !== seq[k]) begin
        errors++; $display("FAIL bp_order%0d got %b/%h exp 1/%h", k, ex_valid, ex_inst, seq[k]);
      end
      c_taken = if_valid && (exp_q.size() < 2);
      cycle();
      if (c_taken) if_valid = 1'b0;
    end
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", ex_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] head, dropped;
    ex_ready = 1'b0;
    head = 32'h00A00513;
    if_valid = 1'b1; if_inst = head; if_pc = 32'h200; cycle();
    if_inst = 32'h00B00593; if_pc = 32'h204; cycle();
    for (int k = 0; k < 3; k++) begin
      if_inst = {$urandom_range(0, 32'h01FF_FFFF), 7'b0010011};
      cycle();
      checks++; if (ex_inst !== head || id_ready !== 1'b0) begin
        errors++; $display("FAIL hold%0d got %h/%b exp %h/0", k, ex_inst, id_ready, head);
      end
    end
    dropped = 32'h0DEAD037;
    if_inst = dropped; flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got valid %b ready %b exp 0/1", ex_valid, id_ready);
    end
    if_valid = 1'b0; ex_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ex_valid !== 1'b0 || ex_inst !== 32'h0) begin
        errors++; $display("FAIL flush_drop%0d got %b/%h exp 0/0", k, ex_valid, ex_inst);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    if_valid = 1'b1; if_inst = 32'h00C00613; if_pc = 32'h300; cycle();
    if_inst = 32'h00D00693; if_pc = 32'h304; cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; if_valid = 1'b0;
    checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b1 || {ex_inst, ex_pc, ex_imm, ex_fmt, ex_illegal} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got v%b r%b %h %h %h exp 0/1/0", ex_valid, id_ready, ex_inst, ex_pc, ex_imm);
    end
    ex_ready = 1'b1;
    if_valid = 1'b1; if_inst = 32'h00E00713; if_pc = 32'h400;
    cycle();
    if_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1 || ex_inst !== 32'h00E00713 || ex_pc !== 32'h400) begin
      errors++; $display("FAIL rstmid_after got %b/%h/%h exp 1/00e00713/00000400", ex_valid, ex_inst, ex_pc);
    end
    cycle();
  endtask

  task automatic test_illegal_fp();
    ex_ready = 1'b1;
    if_valid = 1'b1; if_inst = 32'h0000007F; if_pc = 32'h500;
    cycle();
    checks++; if (ex_illegal !== 1'b1) begin errors++; $display("FAIL illegal_7f got %b exp 1", ex_illegal); end
    if_inst = 32'h00A12427; if_pc = 32'h504;
    cycle();
    if_valid = 1'b0;
    checks++; if (ex_fmt !== 5'b00100 || ex_imm !== 32'h8 || ex_illegal !== 1'b0) begin
      errors++; $display("FAIL fsw_on got %b/%h/%b exp 00100/00000008/0", ex_fmt, ex_imm, ex_illegal);
    end
    checks++; if (nf_ex_illegal !== 1'b1 || nf_ex_fmt !== 5'b00000 || nf_ex_imm !== 32'h0000000A) begin
      errors++; $display("FAIL fsw_off got %b/%b/%h exp 1/00000/0000000a", nf_ex_illegal, nf_ex_fmt, nf_ex_imm);
    end
    cycle();
  endtask

  task automatic test_random();
    logic [6:0] ops[16] = '{7'h6F, 7'h63, 7'h23, 7'h27, 7'h37, 7'h17, 7'h03, 7'h07,
                            7'h13, 7'h33, 7'h67, 7'h43, 7'h4F, 7'h7F, 7'h0B, 7'h5B};
    logic [31:0] r, ei;
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      if_valid = ($urandom_range(0, 3) != 0);
      if_inst  = {r[31:7], ops[$urandom_range(0, 15)]};
      if_pc    = $urandom();
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 39) == 0);
      checks++; if (id_ready !== (exp_q.size() < 2) || nf_id_ready !== (exp_q.size() < 2)) begin
        errors++; $display("FAIL rand_ready@%0d got %b/%b exp %b", n, id_ready, nf_id_ready, exp_q.size() < 2);
      end
      checks++; if (ex_valid !== (exp_q.size() > 0)) begin
        errors++; $display("FAIL rand_valid@%0d got %b exp %b", n, ex_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        ei = exp_q[0];
        checks++; if (ex_inst !== ei || ex_pc !== pc_q[0]) begin
          errors++; $display("FAIL rand_entry@%0d got %h/%h exp %h/%h", n, ex_inst, ex_pc, ei, pc_q[0]);
        end
        checks++; if (ex_imm !== ref_imm(ei, 1'b1) || ex_fmt !== ref_fmt(ei, 1'b1) || ex_illegal !== ref_illegal(ei, 1'b1)) begin
          errors++; $display("FAIL rand_decode@%0d inst %h got %h/%b/%b exp %h/%b/%b", n, ei, ex_imm, ex_fmt, ex_illegal,
                             ref_imm(ei, 1'b1), ref_fmt(ei, 1'b1), ref_illegal(ei, 1'b1));
        end
        checks++; if (nf_ex_imm !== ref_imm(ei, 1'b0) || nf_ex_fmt !== ref_fmt(ei, 1'b0) || nf_ex_illegal !== ref_illegal(ei, 1'b0)) begin
          errors++; $display("FAIL rand_nofp@%0d inst %h got %h/%b/%b exp %h/%b/%b", n, ei, nf_ex_imm, nf_ex_fmt, nf_ex_illegal,
                             ref_imm(ei, 1'b0), ref_fmt(ei, 1'b0), ref_illegal(ei, 1'b0));
        end
      end else begin
        checks++; if ({ex_inst, ex_pc, ex_imm, ex_fmt, ex_illegal} !== '0) begin
          errors++; $display("FAIL rand_idle@%0d got %h %h %h %b %b exp all 0", n, ex_inst, ex_pc, ex_imm, ex_fmt, ex_illegal);
        end
      end
      cycle();
    end
    flush = 1'b0; if_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of tests");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_formats();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_illegal_fp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_imm_ctrl.md
# decode_imm_ctrl

Decode-stage sequencer that accepts fetched instructions over a valid/ready handshake and classifies each opcode into the immediate-format selects. It drives the `imm_gen` instance from those selects and registers the instruction, PC, immediate and format flags into a two-entry skid buffer feeding execute. It sits between the IF/ID boundary and the ID/EX pipeline register of the RV32IMF core, and owns stall and flush behaviour for the immediate path.

## Interface
- `EN_FP_STORE`, default 1: when 1, opcode 0100111 (FSW) is classified S-type; when 0, it is treated as illegal.
- `ILLEGAL_DETECT`, default 1: when 1, `ex_illegal` flags unrecognised opcodes; when 0, `ex_illegal` is tied 0.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous pipeline kill from branch/trap resolution.
- `if_valid` in 1: fetch presents an instruction.
- `if_inst` in 32: instruction word.
- `if_pc` in 32: instruction PC.
- `id_ready` out 1: stage can accept; registered; equals NOT skid-occupied.
- `ex_valid` out 1: main entry holds a valid instruction.
- `ex_ready` in 1: execute consumes the main entry.
- `ex_inst` out 32: registered instruction.
- `ex_pc` out 32: registered PC.
- `ex_imm` out 32: registered, sign/format-extended immediate.
- `ex_fmt` out 5: {j_type, b_type, s_type, lui, auipc}, registered.
- `ex_illegal` out 1: opcode not in the supported set.

## Operation
- Classification on `if_inst[6:0]`:
  - 1101111 → j.
  - 1100011 → b.
  - 0100011 and 0100111 (if `EN_FP_STORE`) → s.
  - 0110111 → lui.
  - 0010111 → auipc.
  - Anything else → all selects 0, so `imm_gen` produces I-format.
- Legal I/R-format opcodes: 0000011, 0000111, 0010011, 0110011, 1100111, 1110011, 0001111, 1010011, 1000011–1001111 (FMA group). Any other opcode sets `ex_illegal`. `ex_imm` is still the I-format value.
- The immediate is computed combinationally from `if_inst` at accept time and stored with the entry. Downstream never recomputes it.
- Storage is one main entry plus one skid entry. Each entry holds {inst, pc, imm, fmt, illegal}.
- FSM states: EMPTY, ONE (main valid), TWO (main and skid valid).
  - Input transfer: `in_xfer = if_valid & id_ready`.
  - Output transfer: `out_xfer = ex_valid & ex_ready`.
  - EMPTY: `in_xfer` → ONE, load main.
  - ONE, `in_xfer & out_xfer` → ONE, main overwritten with new entry.
  - ONE, `in_xfer & !out_xfer` → TWO, new entry into skid.
  - ONE, `!in_xfer & out_xfer` → EMPTY.
  - TWO: `id_ready`=0. `out_xfer` → ONE, skid moves to main. Otherwise hold.
- `flush` has priority over all transfers. Next state is EMPTY and both entries are invalidated. An instruction presented the same cycle is dropped, not accepted. `id_ready` is 1 the following cycle.
- `reset` has priority over `flush`. Next state is EMPTY.
- Data registers update only on load. Invalid entries keep stale data, but outputs are forced to 0 while `ex_valid`=0.

## Timing
- Accept-to-`ex_valid` latency is 1 cycle. Throughput is 1 instruction/cycle while `ex_ready`=1.
- `id_ready` is purely registered, with no combinational path from `ex_ready`.
- After reset: state EMPTY, `id_ready`=1, `ex_valid`=0, and `ex_inst`, `ex_pc`, `ex_imm`, `ex_fmt`, `ex_illegal` are all 0.
- Reset asserted mid-operation: both entries are dropped at the next edge and no partial transfer completes. `ex_valid`=0 in the cycle after the edge.
- While in TWO with `ex_ready` held 0, all outputs stay stable indefinitely. `if_inst` may change without effect.
- Ordering is strictly FIFO. Skid contents never bypass main.

## Structure
- Package `decode_imm_pkg`:
  - Opcode localparams: OP_JAL, OP_BRANCH, OP_STORE, OP_FSTORE, OP_LUI, OP_AUIPC, and the legal I/R list.
  - `state_t` enum: EMPTY, ONE, TWO.
  - Packed `id_entry_t` struct for the entry fields.
- One sub-module: the existing `imm_gen`, instantiated once on the input side with the five selects.
- Classification logic and FSM live in this module.

## Test plan
- **Format decode** (reset, then one instruction each, `ex_ready`=1):
  - JAL 0x0080006F → `ex_imm`=0x00000008, `ex_fmt`=10000.
  - BEQ 0xFE000EE3 → `ex_imm`=0xFFFFFFFC, `ex_fmt`=01000.
  - SW 0xFE112C23 → `ex_imm`=0xFFFFFFF8, `ex_fmt`=00100.
  - LUI 0x123450B7 → `ex_imm`=0x12345000, `ex_fmt`=00010.
  - ADDI 0xFFF00093 → `ex_imm`=0xFFFFFFFF, `ex_fmt`=00000.
- **Backpressure**: stream A, B, C with `ex_ready`=0 → after 2 cycles `id_ready`=0 and `ex_inst`=A. C is not accepted. Release `ex_ready` → A, B, C emerge in order, one per cycle, with no loss or duplication.
- **Flush in TWO**: assert `flush` while `if_valid`=1 → next cycle `ex_valid`=0, `id_ready`=1. The presented instruction never appears at the output.
- **Reset mid-stream**: state TWO, assert `reset` for 1 cycle → all outputs 0 and `id_ready`=1 in the next cycle. A subsequent single instruction appears 1 cycle after accept.
- **Illegal and FP store**:
  - 0x0000007F → `ex_illegal`=1.
  - FSW 0x00A12427 with `EN_FP_STORE`=1 → `ex_fmt`=00100, `ex_imm`=0x00000008.
  - Same word with `EN_FP_STORE`=0 → `ex_illegal`=1.
